// File: rtl/key_schedule_ctrl.sv
// Sequencer for the single-round AES key expansion block: drives Nr rounds and keeps rk[0..Nr] in a register file.
// Optional watchdog on the round-block handshake is compiled in with `define KEY_SCHED_TIMEOUT_EN.
module key_schedule_ctrl #(
  parameter int KEY_LENGTH = 128,
  parameter int Nr         = 10,
  parameter int I_STEP     = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LENGTH-1:0] key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  keys_valid,
  output logic                  rnd_i_valid,
  output logic [7:0]            rnd_i,
  output logic [KEY_LENGTH-1:0] rnd_key,
  input  logic                  rnd_o_valid,
  input  logic [KEY_LENGTH-1:0] rnd_sched,
  input  logic [3:0]            rk_rd_addr,
  output logic [KEY_LENGTH-1:0] rk_rd_data,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST  = 4'(Nr);
  localparam logic [7:0] STEP8 = 8'(I_STEP);

  state_t                state;
  logic [3:0]            r;
  logic [KEY_LENGTH-1:0] rk [0:Nr];

  logic                  rk_we;
  logic [3:0]            rk_wa;
  logic [KEY_LENGTH-1:0] rk_wd;

  // The cipher key lands in rk[0] on acceptance; every round result lands in rk[r].
  assign rk_we = ((state == S_IDLE) && start) || ((state == S_WAIT) && rnd_o_valid);
  assign rk_wa = (state == S_IDLE) ? 4'd0 : r;
  assign rk_wd = (state == S_IDLE) ? key_in : rnd_sched;

  // NOTE: the key store has no reset branch; contents only matter once keys_valid
  // is set, and leaving it out keeps the array as plain enabled flops/RAM.
  always_ff @(posedge clk) begin
    if (reset && rk_we) rk[rk_wa] <= rk_wd;
  end

  assign rk_rd_data = (rk_rd_addr <= LAST) ? rk[rk_rd_addr] : '0;

`ifdef KEY_SCHED_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      keys_valid  <= 1'b0;
      rnd_i_valid <= 1'b0;
      rnd_i       <= '0;
      rnd_key     <= '0;
`ifdef KEY_SCHED_TIMEOUT_EN
      err         <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      done        <= 1'b0;
      rnd_i_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rnd_key     <= key_in;
            r           <= 4'd1;
            keys_valid  <= 1'b0;
            busy        <= 1'b1;
            rnd_i_valid <= 1'b1;
            rnd_i       <= STEP8;
            state       <= S_ISSUE;
`ifdef KEY_SCHED_TIMEOUT_EN
            err         <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef KEY_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (rnd_o_valid) begin
            rnd_key <= rnd_sched;
            if (r == LAST) begin
              done       <= 1'b1;
              keys_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              // Strobe is raised on the way into ISSUE so it is high for that whole cycle.
              r           <= r + 4'd1;
              rnd_i       <= 8'({4'd0, r + 4'd1} * STEP8);
              rnd_i_valid <= 1'b1;
              state       <= S_ISSUE;
            end
          end
`ifdef KEY_SCHED_TIMEOUT_EN
          else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
`endif
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
